rst_seq_ctrl: RTL and testbench

Reset sequencing controller that sits directly behind the chip-level asynchronous reset input.
- Synchronizes reset deassertion internally.
- Releases NUM_DOMAINS downstream reset domains one at a time, in index order, with a programmable gap between releases.
- Provides a software soft-reset request/acknowledge handshake that re-asserts all domains and re-runs the release sequence.
- Each DOM_RST_N output feeds one functional block's active-low reset.

---
 rtl/rst_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl
//
// Reset sequencing controller placed directly behind the chip-level
// asynchronous reset. Reset assertion is immediate; deassertion is
// synchronized through a NUM_STAGES flop chain. Once synchronized, the
// NUM_DOMAINS downstream resets are released one at a time in index order
// with a programmable gap. A software soft-reset request re-asserts every
// domain, holds them, re-runs the release sequence and acknowledges with a
// single-cycle pulse when it completes.
//
// Ports:
//   CLK          in   single clock for all logic
//   RST          in   asynchronous active-low reset (deassertion synchronized)
//   HOLD_CYCLES  in   gap/hold length, sampled only when the counter loads
//   SW_RST_REQ   in   soft-reset request, rising edge honoured only in RUN
//   SW_RST_ACK   out  one-cycle pulse when a soft-reset sequence completes
//   DOM_RST_N    out  active-low domain resets, bit 0 released first
//   RST_BUSY     out  high whenever any DOM_RST_N bit is low
// -----------------------------------------------------------------------------
module rst_seq_ctrl #(
   parameter int NUM_STAGES  = 2,
   parameter int NUM_DOMAINS = 3,
   parameter int DELAY_W     = 4
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [DELAY_W-1:0]     HOLD_CYCLES,
   input  logic                   SW_RST_REQ,
   output logic                   SW_RST_ACK,
   output logic [NUM_DOMAINS-1:0] DOM_RST_N,
   output logic                   RST_BUSY
);

   localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

   typedef enum logic [1:0] {
      S_SYNC,
      S_REL,
      S_RUN,
      S_ASSERT
   } state_t;

   logic [NUM_STAGES-1:0]  r_sync;
   state_t                 r_state;
   logic [DELAY_W-1:0]     r_cnt;
   logic [IDX_W-1:0]       r_idx;
   logic                   r_req_d;
   logic                   r_sw_seq;
   logic [NUM_DOMAINS-1:0] r_dom;
   logic                   r_busy;
   logic                   r_ack;

   logic                   w_rst_sync;
   logic                   w_req_rise;

   // Deassertion synchronizer: clears asynchronously, fills with ones after
   // RST rises, so the last stage goes high NUM_STAGES edges later.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[NUM_STAGES-2:0], 1'b1};
      end
   end

   assign w_rst_sync = r_sync[NUM_STAGES-1];
   assign w_req_rise = SW_RST_REQ & ~r_req_d;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state  <= S_SYNC;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_req_d  <= 1'b0;
         r_sw_seq <= 1'b0;
         r_dom    <= '0;
         r_busy   <= 1'b1;
         r_ack    <= 1'b0;
      end else begin
         // Edge-detect history runs in every state so a request that was
         // already high when RUN is reached never looks like a new edge.
         r_req_d <= SW_RST_REQ;
         r_ack   <= 1'b0;

         case (r_state)
            S_SYNC: begin
               if (w_rst_sync) begin
                  r_state <= S_REL;
                  r_cnt   <= HOLD_CYCLES;
                  r_idx   <= '0;
               end
            end

            S_REL: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - DELAY_W'(1);
               end else begin
                  // Reload every release so a HOLD_CYCLES change only
                  // affects the gap that starts after it.
                  r_cnt <= HOLD_CYCLES;
                  for (int i = 0; i < NUM_DOMAINS; i++) begin
                     if (r_idx == IDX_W'(i)) begin
                        r_dom[i] <= 1'b1;
                     end
                  end
                  if (r_idx == LAST_IDX) begin
                     r_state <= S_RUN;
                     r_busy  <= 1'b0;
                     if (r_sw_seq) begin
                        r_ack    <= 1'b1;
                        r_sw_seq <= 1'b0;
                     end
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end
            end

            S_RUN: begin
               if (w_req_rise) begin
                  r_state  <= S_ASSERT;
                  r_dom    <= '0;
                  r_busy   <= 1'b1;
                  r_cnt    <= HOLD_CYCLES;
                  r_sw_seq <= 1'b1;
               end
            end

            S_ASSERT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - DELAY_W'(1);
               end else begin
                  r_state <= S_REL;
                  r_cnt   <= HOLD_CYCLES;
                  r_idx   <= '0;
               end
            end

            default: begin
               r_state <= S_SYNC;
            end
         endcase
      end
   end

   assign SW_RST_ACK = r_ack;
   assign DOM_RST_N  = r_dom;
   assign RST_BUSY   = r_busy;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_ctrl
//
// Directed scoreboard bench for rst_seq_ctrl with default parameters.
// Stimulus pushes every expected output change (cycle number and value) into
// a queue; a monitor process watches the outputs and pops/compares each time
// they change, including changes caused by asynchronous reset assertion.
// -----------------------------------------------------------------------------
module tb_rst_seq_ctrl;

   logic       CLK;
   logic       RST;
   logic [3:0] HOLD_CYCLES;
   logic       SW_RST_REQ;
   logic       SW_RST_ACK;
   logic [2:0] DOM_RST_N;
   logic       RST_BUSY;

   rst_seq_ctrl #(
      .NUM_STAGES (2),
      .NUM_DOMAINS(3),
      .DELAY_W    (4)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .HOLD_CYCLES(HOLD_CYCLES),
      .SW_RST_REQ (SW_RST_REQ),
      .SW_RST_ACK (SW_RST_ACK),
      .DOM_RST_N  (DOM_RST_N),
      .RST_BUSY   (RST_BUSY)
   );

   typedef struct {
      int         cyc;    // -1 means any cycle
      logic [2:0] dom;
      logic       busy;
      logic       ack;
      string      name;
   } exp_t;

   exp_t q[$];
   int   cyc        = 0;
   int   total      = 0;
   int   bad        = 0;
   logic finish_req = 1'b0;
   logic [4:0] mon_last = 5'bxxxxx;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc = cyc + 1;

   task automatic push(input int c, input logic [2:0] d, input logic b,
                       input logic a, input string n);
      exp_t e;
      e.cyc  = c;
      e.dom  = d;
      e.busy = b;
      e.ack  = a;
      e.name = n;
      q.push_back(e);
   endtask

   // Stimulus moves at negedge+2; the monitor samples at negedge+1.
   task automatic wait_edges(input int n);
      repeat (n) @(negedge CLK);
      #2;
   endtask

   // Asserts RST between edges; outputs must drop before the next edge.
   task automatic do_reset();
      push(cyc, 3'b000, 1'b1, 1'b0, "async_reset");
      RST        = 1'b0;
      SW_RST_REQ = 1'b0;
   endtask

   // RST low for 5 cycles, then released. Gap h before the first two
   // releases, HOLD_CYCLES switched to h2 right after domain 0 releases.
   task automatic power_on(input int h, input int h2, input bit drop);
      int base, t0, t1, t2;
      HOLD_CYCLES = 4'(h);
      wait_edges(5);
      base = cyc;
      t0 = base + 3 + (h + 1);
      t1 = t0 + (h + 1);
      t2 = t1 + (h2 + 1);
      push(t0, 3'b001, 1'b1, 1'b0, "rel_dom0");
      push(t1, 3'b011, 1'b1, 1'b0, "rel_dom1");
      push(t2, 3'b111, 1'b0, 1'b0, "rel_dom2");
      RST = 1'b1;
      wait_edges(5);
      if (drop) SW_RST_REQ = 1'b1;
      wait_edges(1);
      SW_RST_REQ = 1'b0;
      while (cyc < t0) wait_edges(1);
      HOLD_CYCLES = 4'(h2);
      while (cyc < t2 + 3) wait_edges(1);
   endtask

   // Monitor: compares on every output change, clock-driven or asynchronous.
   always begin : monitor
      logic [4:0] cur;
      logic [4:0] req;
      exp_t       e;
      @(negedge CLK or negedge RST);
      #1;
      cur = {DOM_RST_N, RST_BUSY, SW_RST_ACK};
      if (cur !== mon_last) begin
         total = total + 1;
         if (q.size() == 0) begin
            bad = bad + 1;
            $display("FAIL unexpected_change cyc=%0d got dom=%b busy=%b ack=%b required no change",
                     cyc, DOM_RST_N, RST_BUSY, SW_RST_ACK);
         end else begin
            e   = q.pop_front();
            req = {e.dom, e.busy, e.ack};
            if ((e.cyc >= 0 && e.cyc != cyc) || cur !== req) begin
               bad = bad + 1;
               $display("FAIL %s got cyc=%0d dom=%b busy=%b ack=%b required cyc=%0d dom=%b busy=%b ack=%b",
                        e.name, cyc, DOM_RST_N, RST_BUSY, SW_RST_ACK,
                        e.cyc, e.dom, e.busy, e.ack);
            end
         end
         mon_last = cur;
      end
      if (finish_req) begin
         total = total + 1;
         if (q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL missing_events got pending=%0d required 0 (next %s)",
                     q.size(), q[0].name);
         end
         $display("test done: total=%0d bad=%0d", total, bad);
         $finish;
      end
   end

   initial begin : stim
      int m;
      RST         = 1'b0;
      SW_RST_REQ  = 1'b0;
      HOLD_CYCLES = 4'd3;
      push(-1, 3'b000, 1'b1, 1'b0, "reset_state");

      // 1: power-on, gap 3 -> releases at edges 7, 11, 15
      power_on(3, 3, 1'b0);

      // 2: zero gap -> releases at edges 4, 5, 6
      do_reset();
      power_on(0, 0, 1'b0);

      // 3: soft reset with gap 2, request held high afterwards
      HOLD_CYCLES = 4'd2;
      m = cyc;
      push(m + 1,  3'b000, 1'b1, 1'b0, "soft_assert");
      push(m + 7,  3'b001, 1'b1, 1'b0, "soft_dom0");
      push(m + 10, 3'b011, 1'b1, 1'b0, "soft_dom1");
      push(m + 13, 3'b111, 1'b0, 1'b1, "soft_dom2_ack");
      push(m + 14, 3'b111, 1'b0, 1'b0, "ack_end");
      SW_RST_REQ = 1'b1;
      wait_edges(14 + 10);
      SW_RST_REQ = 1'b0;
      wait_edges(3);

      // 4: request pulse during REL is dropped
      do_reset();
      power_on(3, 3, 1'b1);
      wait_edges(6);

      // 5: RST asserted while 011 during a soft sequence (gap 1)
      HOLD_CYCLES = 4'd1;
      m = cyc;
      push(m + 1, 3'b000, 1'b1, 1'b0, "soft5_assert");
      push(m + 5, 3'b001, 1'b1, 1'b0, "soft5_dom0");
      push(m + 7, 3'b011, 1'b1, 1'b0, "soft5_dom1");
      SW_RST_REQ = 1'b1;
      wait_edges(7);
      do_reset();
      power_on(1, 1, 1'b0);
      wait_edges(4);

      // 6: HOLD_CYCLES 3 -> 1 after domain 0: gaps 4 then 2
      do_reset();
      power_on(3, 1, 1'b0);

      finish_req = 1'b1;
      wait_edges(3);
      $display("FAIL monitor_finish got no summary required summary");
      $fatal(1);
   end

endmodule
